// File: rtl/lcd_stream_pkg.sv
// Shared definitions for the LCD data-path stream adapters.
// Provides the default symbol width, empty-field sizing and MSB-first symbol selection.
package lcd_stream_pkg;

  localparam int SYMBOL_WIDTH_DEFAULT = 8;
  localparam int MAX_BEAT_WIDTH       = 256;
  localparam int MAX_SYMBOL_WIDTH     = 32;

  // A single-symbol stream still needs a 1-bit empty field to keep port widths legal.
  function automatic int empty_width(input int symbols);
    return (symbols <= 1) ? 1 : $clog2(symbols);
  endfunction

  function automatic logic [MAX_SYMBOL_WIDTH-1:0] select_symbol(
    input logic [MAX_BEAT_WIDTH-1:0] data,
    input int                        idx,
    input int                        symbols,
    input int                        symbol_width
  );
    int shift;
    shift = (symbols - 1 - idx) * symbol_width;
    return MAX_SYMBOL_WIDTH'(data >> shift);
  endfunction

endpackage

// File: rtl/lcd_data_width_unpacker.sv
// Avalon-ST narrowing adapter: splits multi-symbol beats into one symbol per output beat,
// honouring the empty field on end-of-packet beats and preserving packet framing.
module lcd_data_width_unpacker
  import lcd_stream_pkg::*;
#(
  parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_DEFAULT,
  parameter int SYMBOLS_IN   = 2,
  parameter int EMPTY_WIDTH  = empty_width(SYMBOLS_IN)
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             in_ready,
  input  logic                             in_valid,
  input  logic [SYMBOL_WIDTH*SYMBOLS_IN-1:0] in_data,
  input  logic                             in_startofpacket,
  input  logic                             in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]           in_empty,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [SYMBOL_WIDTH-1:0]          out_data,
  output logic                             out_startofpacket,
  output logic                             out_endofpacket
);

  localparam int BEAT_WIDTH = SYMBOL_WIDTH * SYMBOLS_IN;
  localparam logic [EMPTY_WIDTH-1:0] LAST_FULL = EMPTY_WIDTH'(SYMBOLS_IN - 1);

  logic [BEAT_WIDTH-1:0]  hold_data;
  logic                   hold_sop;
  logic                   hold_eop;
  logic [EMPTY_WIDTH-1:0] hold_empty;
  logic                   hold_valid;
  logic [EMPTY_WIDTH-1:0] idx;

  logic [EMPTY_WIDTH-1:0] last_idx;
  logic                   at_last;
  logic                   capture;
  logic                   advance;

  always_comb begin
    last_idx = hold_eop ? (LAST_FULL - hold_empty) : LAST_FULL;
    at_last  = (idx == last_idx);
  end

  // Releasing the last symbol and accepting the next beat happen on the same edge,
  // which is what keeps the output stream bubble-free.
  assign in_ready = !reset && (!hold_valid || (out_ready && at_last));
  assign capture  = in_valid && in_ready;
  assign advance  = hold_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data  <= '0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
      hold_empty <= '0;
      hold_valid <= 1'b0;
      idx        <= '0;
    end else if (capture) begin
      hold_data  <= in_data;
      hold_sop   <= in_startofpacket;
      hold_eop   <= in_endofpacket;
      hold_empty <= in_endofpacket ? in_empty : '0;
      hold_valid <= 1'b1;
      idx        <= '0;
    end else if (advance) begin
      if (at_last) begin
        hold_valid <= 1'b0;
      end else begin
        idx <= idx + EMPTY_WIDTH'(1);
      end
    end
  end

  always_comb begin
    out_valid         = hold_valid;
    out_data          = SYMBOL_WIDTH'(select_symbol(MAX_BEAT_WIDTH'(hold_data), int'(idx),
                                                    SYMBOLS_IN, SYMBOL_WIDTH));
    out_startofpacket = hold_sop && (idx == '0);
    out_endofpacket   = hold_eop && at_last;
  end

endmodule

// File: tb/tb_lcd_data_width_unpacker.sv
// Directed self-checking bench for lcd_data_width_unpacker (8-bit symbols, 2 per beat).
// A monitor records every accepted output symbol as {sop, eop, data} for sequence checks.
module tb_lcd_data_width_unpacker;

  logic        clk;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [0:0]  in_empty;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [9:0] obs_q[$];
  int         obs_cyc[$];

  lcd_data_width_unpacker dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_q.push_back({out_startofpacket, out_endofpacket, out_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [15:0] d, input logic sop, input logic eop, input logic emp);
    logic hs;
    int   n;
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = sop;
    in_endofpacket = eop;
    in_empty = emp;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      step();
      n++;
    end
    if (!hs) checkOutput("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic checkSeq(input string tag, input logic [9:0] exp[$]);
    checkOutput({tag, "_count"}, obs_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput($sformatf("%s_sym%0d", tag, i),
                  (i < obs_q.size()) ? {22'd0, obs_q[i]} : 32'hFFFF_FFFF, {22'd0, exp[i]});
    end
  endtask

  initial begin
    logic [9:0] exp[$];

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    in_empty = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_sop_eop", {out_startofpacket, out_endofpacket}, 0);
    checkOutput("rst_out_data", out_data, 0);
    reset = 1'b0;
    step();

    // Basic split of a single-beat packet
    in_valid = 1'b1;
    in_data = 16'hA1B2;
    in_startofpacket = 1'b1;
    in_endofpacket = 1'b1;
    in_empty = 1'b0;
    @(negedge clk);
    checkOutput("basic_in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("basic_c1_valid", out_valid, 1);
    checkOutput("basic_c1_data", out_data, 32'hA1);
    checkOutput("basic_c1_sop_eop", {out_startofpacket, out_endofpacket}, 2'b10);
    checkOutput("basic_c1_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    checkOutput("basic_c2_data", out_data, 32'hB2);
    checkOutput("basic_c2_sop_eop", {out_startofpacket, out_endofpacket}, 2'b01);
    checkOutput("basic_c2_in_ready", in_ready, 1);
    step();
    @(negedge clk);
    checkOutput("basic_c3_valid", out_valid, 0);
    repeat (2) step();

    // Empty on the eop beat drops the trailing symbol
    obs_q.delete();
    obs_cyc.delete();
    applyStimulus(16'h1122, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h3344, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h5566, 1'b0, 1'b1, 1'b1);
    repeat (4) step();
    exp = '{10'h211, 10'h022, 10'h033, 10'h044, 10'h155};
    checkSeq("empty", exp);

    // Back-to-back throughput
    obs_q.delete();
    obs_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      applyStimulus({8'(2 * k), 8'(2 * k + 1)}, k == 0, k == 7, 1'b0);
    end
    repeat (4) step();
    exp.delete();
    for (int i = 0; i < 16; i++) begin
      exp.push_back({i == 0, i == 15, 8'(i)});
    end
    checkSeq("b2b", exp);
    checkOutput("b2b_span", (obs_cyc.size() == 16) ? obs_cyc[15] - obs_cyc[0] : -1, 15);

    // Backpressure: out_ready 1,0,0,1
    applyStimulus(16'hC3D4, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_c1_data", out_data, 32'hC3);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_c2_data", out_data, 32'hD4);
    checkOutput("bp_c2_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    checkOutput("bp_c3_data", out_data, 32'hD4);
    checkOutput("bp_c3_valid_eop", {out_valid, out_endofpacket}, 2'b11);
    checkOutput("bp_c3_in_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_c4_data", out_data, 32'hD4);
    checkOutput("bp_c4_in_ready", in_ready, 1);
    step();
    @(negedge clk);
    checkOutput("bp_done_valid", out_valid, 0);
    repeat (2) step();

    // Non-zero empty on a non-eop beat is ignored
    obs_q.delete();
    obs_cyc.delete();
    applyStimulus(16'h7788, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h99AA, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    exp = '{10'h277, 10'h088, 10'h099, 10'h1AA};
    checkSeq("ign_empty", exp);

    // Reset mid-packet discards the held beat
    obs_q.delete();
    obs_cyc.delete();
    out_ready = 1'b0;
    applyStimulus(16'hEEFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_held_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready_hi", in_ready, 0);
    @(negedge clk);
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_rel_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) step();
    checkOutput("rst_no_output", obs_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_data_width_unpacker.md
Name: lcd_data_width_unpacker

Overview:
- Avalon-ST narrowing adapter on the LCD data path.
- Accepts multi-symbol beats with an empty field and emits one symbol per beat on an 8-bit stream, with packet framing preserved.
- Sits where a wide packet source (e.g. 16-bit pixel/command DMA stream) meets the 8-bit LCD data interface. It consumes the empty signal that format adapters on that path generate.

Parameters:
- SYMBOL_WIDTH, 8, bits per symbol.
- SYMBOLS_IN, 2, symbols per input beat (must be >= 2, power of two).
- EMPTY_WIDTH, 1, width of in_empty; equals log2(SYMBOLS_IN).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_ready  output  1  sink ready.
- in_valid  input  1  input beat valid.
- in_data  input  SYMBOL_WIDTH*SYMBOLS_IN  symbols; first symbol in MSBs.
- in_startofpacket  input  1  first beat of packet.
- in_endofpacket  input  1  last beat of packet.
- in_empty  input  EMPTY_WIDTH  unused trailing (LSB-side) symbols on the eop beat.
- out_ready  input  1  downstream ready.
- out_valid  output  1  output symbol valid.
- out_data  output  SYMBOL_WIDTH  current symbol.
- out_startofpacket  output  1  first symbol of packet.
- out_endofpacket  output  1  last valid symbol of packet.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - While reset is high: hold_valid=0, idx=0, out_valid=0, out_sop=0, out_eop=0, in_ready=0.
  - out_data is don't-care, but is cleared to 0.
  - Asserting reset mid-packet discards the held beat and all remaining symbols. No partial output follows reset.
- State:
  - Holding register: data, sop, eop, empty.
  - hold_valid flag.
  - Symbol index idx (EMPTY_WIDTH bits).
- last_idx:
  - On an eop beat: SYMBOLS_IN-1-empty.
  - On any other beat: SYMBOLS_IN-1. A non-zero in_empty on a non-eop beat is ignored (treated as 0).
- Capture:
  - Input handshake occurs when in_valid && in_ready.
  - The beat is written to the holding register, hold_valid=1, idx=0.
  - Latency: 1 cycle from input handshake to first out_valid.
- Output decode (from registers):
  - out_valid = hold_valid.
  - out_data = symbol idx, where symbol 0 is the MSBs.
  - out_startofpacket = hold_sop && idx==0.
  - out_endofpacket = hold_eop && idx==last_idx.
- Advance:
  - On out_valid && out_ready with idx!=last_idx: idx increments.
  - On out_valid && out_ready with idx==last_idx: hold_valid clears, unless a new beat is captured in the same cycle.
- in_ready = !reset && (!hold_valid || (out_ready && idx==last_idx)).
  - This gives a combinational out_ready->in_ready path, by design.
  - It allows back-to-back beats with no bubble: sustained throughput is 1 symbol/cycle.
- Simultaneous release and capture: the new beat loads and idx resets to 0 in the same edge. out_valid stays high.
- Backpressure: when out_ready=0, all outputs hold stable, idx holds, in_ready=0 (if hold_valid).
- Single-beat packet (sop and eop on one beat): the first symbol carries both sop; the symbol at last_idx carries eop. With SYMBOLS_IN=2 and empty=1, one symbol carries both sop and eop.
- in_valid deassertion between beats inserts output bubbles only. No state is corrupted.

Decomposition:
- Shared package lcd_stream_pkg:
  - SYMBOL_WIDTH default.
  - EMPTY_WIDTH derivation function (clog2).
  - Symbol-select function (index -> bit slice, MSB-first).
- Single module; no sub-module needed. The holding register and index counter are small enough to inline.

Test Plan:
- Basic split:
  - Stimulus: out_ready=1; one beat data=0xA1B2, sop=1, eop=1, empty=0.
  - Required: cycle+1 out 0xA1 (sop=1, eop=0); cycle+2 out 0xB2 (sop=0, eop=1); in_ready low during cycle+1 only.
- Empty on eop:
  - Stimulus: 3-beat packet 0x1122, 0x3344, 0x5566 with empty=1 on the last beat.
  - Required: output 11,22,33,44,55; eop only on 0x55; 0x66 never emitted.
- Back-to-back throughput:
  - Stimulus: 8 continuous beats with in_valid=1 and out_ready=1.
  - Required: 16 consecutive out_valid cycles with no gap; sop on symbol 0 only, eop on symbol 15 only.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 while emitting 0xC3D4.
  - Required: out_data=0xD4 held stable for 3 cycles; in_ready=0 until the 0xD4 handshake.
- Ignored empty:
  - Stimulus: non-eop beat 0x7788 with empty=1.
  - Required: both 0x77 and 0x88 emitted.
- Reset mid-packet:
  - Stimulus: assert reset one cycle after capturing 0xEEFF, with out_ready=0.
  - Required: out_valid=0 next cycle; in_ready=0 while reset is high and 1 the cycle after release; 0xEE/0xFF never appear.
